// File: rtl/ai_move_engine.sv
// ai_move_engine: bot-side move sequencer for the game FSM's bot handshake.
//
// A request (ai_confirm in idle) snapshots the board. The snapshot is then scanned one line or
// one cell per cycle: winning lines, then blocking lines, then the positional preference list.
// The chosen cell is returned on ai_tick with a one-cycle ai_ack.
//
// Configuration macro: AI_BLOCK_EN
//   defined   - the block scan runs between the win scan and the preference scan
//   undefined - the win scan goes straight to the preference scan
//
// Parameters:
//   THINK_DELAY    extra idle cycles between selection and ai_ack (0..65535)
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   ai_confirm     move request pulse, sampled only in idle
//   cell_position  board, cell i at [2i+1:2i]; 00 empty, 01 player, 10 bot, 11 occupied
//   ai_tick        chosen cell 0..8, 4'hF = no move; held until the next decision
//   ai_ack         one-cycle pulse, ai_tick valid
//   busy           high from request acceptance through the ai_ack cycle
module ai_move_engine #(
  parameter int unsigned THINK_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ai_confirm,
  input  logic [17:0] cell_position,
  output logic [3:0]  ai_tick,
  output logic        ai_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StScanWin,
    StScanBlock,
    StScanPref,
    StThink,
    StResp
  } state_e;

  localparam logic [15:0] Delay = 16'(THINK_DELAY);
  // With no think delay the scan hands over straight to the response cycle.
  localparam state_e DoneSt = (THINK_DELAY == 0) ? StResp : StThink;

  state_e      state_q, state_d;
  logic [17:0] snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] dly_q, dly_d;
  logic [3:0]  tick_q, tick_d;

  logic [4:0]  win_hit;
  logic [3:0]  pref_c;
`ifdef AI_BLOCK_EN
  logic [4:0]  blk_hit;
`endif

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  // Three cell indices of line k, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [3:0] k);
    logic [11:0] r;
    case (k)
      4'd0:    r = {4'd0, 4'd1, 4'd2};
      4'd1:    r = {4'd3, 4'd4, 4'd5};
      4'd2:    r = {4'd6, 4'd7, 4'd8};
      4'd3:    r = {4'd0, 4'd3, 4'd6};
      4'd4:    r = {4'd1, 4'd4, 4'd7};
      4'd5:    r = {4'd2, 4'd5, 4'd8};
      4'd6:    r = {4'd0, 4'd4, 4'd8};
      default: r = {4'd2, 4'd4, 4'd6};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] p);
    logic [3:0] r;
    case (p)
      4'd0:    r = 4'd4;
      4'd1:    r = 4'd0;
      4'd2:    r = 4'd2;
      4'd3:    r = 4'd6;
      4'd4:    r = 4'd8;
      4'd5:    r = 4'd1;
      4'd6:    r = 4'd3;
      4'd7:    r = 4'd5;
      default: r = 4'd7;
    endcase
    return r;
  endfunction

  // {hit, empty cell}: exactly two cells carry mark and the third is empty. A cell of 11 never
  // matches either mark or empty, so such a line cannot hit.
  function automatic logic [4:0] line_hit(input logic [17:0] b, input logic [3:0] k,
                                          input logic [1:0] mark);
    logic [11:0] ln;
    logic [1:0]  va, vb, vc;
    logic [4:0]  r;
    ln = line_cells(k);
    va = cell_at(b, ln[11:8]);
    vb = cell_at(b, ln[7:4]);
    vc = cell_at(b, ln[3:0]);
    if (va == 2'b00 && vb == mark && vc == mark) begin
      r = {1'b1, ln[11:8]};
    end else if (va == mark && vb == 2'b00 && vc == mark) begin
      r = {1'b1, ln[7:4]};
    end else if (va == mark && vb == mark && vc == 2'b00) begin
      r = {1'b1, ln[3:0]};
    end else begin
      r = {1'b0, 4'hF};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      tick_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    tick_d  = tick_q;
    win_hit = line_hit(snap_q, idx_q, 2'b10);
`ifdef AI_BLOCK_EN
    blk_hit = line_hit(snap_q, idx_q, 2'b01);
`endif
    pref_c  = pref_cell(idx_q);

    unique case (state_q)
      StIdle: begin
        if (ai_confirm) begin
          snap_d  = cell_position;
          idx_d   = '0;
          dly_d   = '0;
          state_d = StScanWin;
        end
      end
      StScanWin: begin
        if (win_hit[4]) begin
          tick_d  = win_hit[3:0];
          idx_d   = '0;
          state_d = DoneSt;
        end else if (idx_q == 4'd7) begin
          idx_d   = '0;
`ifdef AI_BLOCK_EN
          state_d = StScanBlock;
`else
          state_d = StScanPref;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`ifdef AI_BLOCK_EN
      StScanBlock: begin
        if (blk_hit[4]) begin
          tick_d  = blk_hit[3:0];
          idx_d   = '0;
          state_d = DoneSt;
        end else if (idx_q == 4'd7) begin
          idx_d   = '0;
          state_d = StScanPref;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      StScanPref: begin
        if (cell_at(snap_q, pref_c) == 2'b00) begin
          tick_d  = pref_c;
          idx_d   = '0;
          state_d = DoneSt;
        end else if (idx_q == 4'd8) begin
          tick_d  = 4'hF;
          idx_d   = '0;
          state_d = DoneSt;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StThink: begin
        // Count saturates at Delay; leaving after Delay cycles spent in this state.
        if (dly_q < Delay) begin
          dly_d = dly_q + 16'd1;
        end
        if (dly_q + 16'd1 >= Delay) begin
          state_d = StResp;
        end
      end
      StResp: begin
        dly_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ai_tick = tick_q;
  assign ai_ack  = (state_q == StResp);
  assign busy    = (state_q != StIdle);

endmodule
